xoodoo_perm_seq_sca: RTL

- Iterative sequencer for the first-order threshold Xoodoo permutation. Sits directly upstream of the masked round core and wraps it in a loop.
- Holds the two 384-bit state shares and feeds them to the core with the round constant and fresh randomness. Captures the core output and repeats for NROUNDS rounds.
- Accepts a masked state via a valid/ready handshake and returns the permuted shares the same way.

---
 rtl/xoodoo_perm_seq_sca_if.sv | 22 ++
 rtl/xoodoo_perm_seq_sca.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/xoodoo_perm_seq_sca_if.sv
// Masked-state handshake bundle for the Xoodoo permutation sequencer.
// Input shares flow in, permuted shares flow out, each with valid/ready.
interface xoodoo_perm_seq_sca_if;
  logic         in_valid;
  logic         in_ready;
  logic [383:0] in_0;
  logic [383:0] in_1;
  logic         out_valid;
  logic         out_ready;
  logic [383:0] out_0;
  logic [383:0] out_1;

  modport master (
    output in_valid, in_0, in_1, out_ready,
    input  in_ready, out_valid, out_0, out_1
  );

  modport slave (
    input  in_valid, in_0, in_1, out_ready,
    output in_ready, out_valid, out_0, out_1
  );
endinterface

// File: rtl/xoodoo_perm_seq_sca.sv
// Iterative sequencer around a masked threshold Xoodoo round core.
// Loops the two state shares through the core for NROUNDS rounds.
module xoodoo_perm_seq_sca #(
  parameter int NROUNDS   = 12,
  parameter int ROUND_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  xoodoo_perm_seq_sca_if.slave io,
  input  logic         rnd_valid,
  output logic         rnd_ready,
  input  logic [767:0] rnd_data,
  output logic [383:0] core_in_0,
  output logic [383:0] core_in_1,
  output logic [383:0] core_rs0,
  output logic [383:0] core_rs1,
  output logic [31:0]  core_rconst,
  input  logic [383:0] core_out_0,
  input  logic [383:0] core_out_1,
  output logic         rnd_starve
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CAPTURE, DONE
  } state_e;

  localparam int RC0 = 12 - NROUNDS;
  localparam int WW  = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(ROUND_LAT - 2);
  localparam logic [3:0] CLAST = 4'(NROUNDS - 1);

  function automatic logic [31:0] rc_f(input int i);
    logic [31:0] r;
    case (i)
      0:       r = 32'h058;
      1:       r = 32'h038;
      2:       r = 32'h3C0;
      3:       r = 32'h0D0;
      4:       r = 32'h120;
      5:       r = 32'h014;
      6:       r = 32'h060;
      7:       r = 32'h02C;
      8:       r = 32'h380;
      9:       r = 32'h0F0;
      10:      r = 32'h1A0;
      11:      r = 32'h012;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [383:0]  st0_q, st0_d;
  logic [383:0]  st1_q, st1_d;
  logic [767:0]  rs_q, rs_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   rc_q, rc_d;
  logic          starve_q, starve_d;

  always_comb begin
    state_d  = state_q;
    st0_d    = st0_q;
    st1_d    = st1_q;
    rs_d     = rs_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    rc_d     = rc_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          st0_d    = io.in_0;
          st1_d    = io.in_1;
          cnt_d    = '0;
          rc_d     = rc_f(RC0);
          starve_d = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (rnd_valid) begin
          rs_d    = rnd_data;
          wcnt_d  = '0;
          state_d = (ROUND_LAT == 1) ? CAPTURE : WAIT;
        end
      end
      WAIT: begin
        // core has no enable: a missing word reuses the old one
        if (rnd_valid) rs_d = rnd_data;
        else starve_d = 1'b1;
        if (wcnt_q == WLAST) state_d = CAPTURE;
        else wcnt_d = wcnt_q + 1'b1;
      end
      CAPTURE: begin
        st0_d = core_out_0;
        st1_d = core_out_1;
        if (cnt_q == CLAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          rc_d    = rc_f(RC0 + int'(cnt_q) + 1);
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      st0_q    <= '0;
      st1_q    <= '0;
      rs_q     <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      rc_q     <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      st0_q    <= st0_d;
      st1_q    <= st1_d;
      rs_q     <= rs_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      rc_q     <= rc_d;
      starve_q <= starve_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_0     = st0_q;
  assign io.out_1     = st1_q;
  assign rnd_ready    = (state_q == ISSUE) || (state_q == WAIT);
  assign core_in_0    = st0_q;
  assign core_in_1    = st1_q;
  assign core_rs0     = rs_q[383:0];
  assign core_rs1     = rs_q[767:384];
  assign core_rconst  = rc_q;
  assign rnd_starve   = starve_q;

endmodule
